// File: rtl/cla_wide_seq.sv
// Sequential NWORDS x 32-bit adder that streams LSW-first through one cla32 and chains carries via a register.
// Optional subtract mode: define CLA_WIDE_SUB_EN to add the `sub` port.

module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] g, p, c;
    logic [7:0]  gg, gp;
    logic [8:0]  gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        // 4-bit groups: group generate/propagate resolve inter-group carries, then bits inside each group
        for (int unsigned k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = ci;
        for (int unsigned k = 0; k < 8; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int unsigned k = 0; k < 8; k++) begin
            c[4*k] = gc[k];
            for (int unsigned i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
        s  = p ^ c;
        co = gc[8];
    end
endmodule

module cla_wide_seq #(
    parameter int unsigned NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [32*NWORDS-1:0]  a,
    input  logic [32*NWORDS-1:0]  b,
    input  logic                  ci,
`ifdef CLA_WIDE_SUB_EN
    input  logic                  sub,
`endif
    output logic [32*NWORDS-1:0]  s,
    output logic                  co,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef logic [NWORDS-1:0][31:0] words_t;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          co_q, co_d;
    words_t        a_q, a_d, b_q, b_d, work_q, work_d, s_q, s_d;
    logic [31:0]   sum_w;
    logic          co_w;

    cla32 u_cla (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .ci (carry_q),
        .s  (sum_w),
        .co (co_w)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        co_d    = co_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
`ifdef CLA_WIDE_SUB_EN
                    b_d     = sub ? ~b : b;
                    carry_d = sub | ci;
`else
                    b_d     = b;
                    carry_d = ci;
`endif
                    idx_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                work_d[idx_q] = sum_w;
                carry_d       = co_w;
                if (idx_q == LAST) begin
                    // publish including the word computed on this same edge
                    s_d     = work_d;
                    co_d    = co_w;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign s    = s_q;
    assign co   = co_q;
    assign busy = (state_q == EXEC);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_cla_wide_seq.sv
// Randomized bench for cla_wide_seq against a cycle-count/arithmetic reference model, plus directed literal cases.
module tb_cla_wide_seq;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned W = 32 * NWORDS;
`ifdef CLA_WIDE_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] s;
    logic         co, busy, done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    cla_wide_seq #(.NWORDS(NWORDS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ci      (ci),
`ifdef CLA_WIDE_SUB_EN
        .sub     (sub),
`endif
        .s       (s),
        .co      (co),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic sb);
        logic [W:0] yy;
        logic       cc;
        yy = (SUB_EN && sb) ? {1'b0, ~y} : {1'b0, y};
        cc = (SUB_EN && sb) ? 1'b1 : c;
        return {1'b0, x} + yy + (W+1)'(cc);
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom % 4)
            0:       return 32'h0;
            1:       return 32'hffff_ffff;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_wide();
        logic [W-1:0] r;
        for (int i = 0; i < int'(NWORDS); i++) r[32*i +: 32] = rnd_word();
        return r;
    endfunction

    // Reference: cyc counts cycles since the accepted start (1..NWORDS busy, NWORDS+1 done)
    int unsigned cyc = 0;
    logic [W:0]  pend = '0;
    logic [W:0]  exp_res = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc     = 0;
            exp_res = '0;
        end else if (cyc == 0) begin
            if (start) begin
                pend = ref_sum(a, b, ci, sub);
                cyc  = 1;
            end
        end else if (cyc <= NWORDS) begin
            cyc++;
            if (cyc == NWORDS + 1) exp_res = pend;
        end else begin
            cyc = 0;
        end
    end

    always @(negedge clk) begin
        chk("busy", (W+1)'(busy), (W+1)'(cyc >= 1 && cyc <= NWORDS));
        chk("done", (W+1)'(done), (W+1)'(cyc == NWORDS + 1));
        chk("s",    {1'b0, s},    {1'b0, exp_res[W-1:0]});
        chk("co",   (W+1)'(co),   (W+1)'(exp_res[W]));
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                      input logic tsub, input bit hold, output int nbusy);
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        @(posedge clk); #2;
        start = 1'b1; a = ta; b = tb_v; ci = tci; sub = tsub;
        @(posedge clk); #2;
        a = rnd_wide(); b = rnd_wide(); ci = ~tci; sub = ~tsub;
        start = hold;
        for (int i = 0; i < int'(3 * NWORDS + 10); i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", '0, (W+1)'(1));
        if (hold) begin
            @(posedge clk); #2;
            start = 1'b0;
            @(negedge clk);
            chk("start_not_queued", (W+1)'(busy), '0);
        end
    endtask

    initial begin
        int  nb;
        bit  seen_done;
        logic [W-1:0] ones;
        ones = '1;

        #12;
        chk("rst_s",    {1'b0, s},    '0);
        chk("rst_co",   (W+1)'(co),   '0);
        chk("rst_busy", (W+1)'(busy), '0);
        chk("rst_done", (W+1)'(done), '0);
        reset_n = 1'b1;

        op('0, '0, 1'b0, 1'b0, 1'b0, nb);
        chk("zero_sum",   {co, s}, '0);
        chk("zero_busyn", (W+1)'(nb), (W+1)'(NWORDS));

        op({4{32'h1234_5678}}, {4{32'h8765_4321}}, 1'b1, 1'b0, 1'b0, nb);
        chk("pat_s",  {1'b0, s}, {1'b0, 128'h99999999_99999999_99999999_9999999a});
        chk("pat_co", (W+1)'(co), '0);

        op(ones, '0, 1'b1, 1'b0, 1'b0, nb);
        chk("ripple_s",  {1'b0, s}, '0);
        chk("ripple_co", (W+1)'(co), (W+1)'(1));

        op({4{32'h0f0f_0f0f}}, '0, 1'b0, 1'b0, 1'b0, nb);
        @(posedge clk); #2;
        start = 1'b1; a = rnd_wide(); b = rnd_wide(); ci = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_s",    {1'b0, s},    '0);
        chk("midrst_co",   (W+1)'(co),   '0);
        chk("midrst_busy", (W+1)'(busy), '0);
        chk("midrst_done", (W+1)'(done), '0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        seen_done = 1'b0;
        repeat (NWORDS + 3) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("midrst_nodone", (W+1)'(seen_done), '0);

        op(rnd_wide(), rnd_wide(), 1'b0, 1'b0, 1'b1, nb);
        chk("hold_busyn", (W+1)'(nb), (W+1)'(NWORDS));
        op(128'd100, 128'd23, 1'b1, 1'b0, 1'b0, nb);
        op(128'd1, ones, 1'b0, 1'b0, 1'b0, nb);
        chk("b2b_s",  {1'b0, s}, '0);
        chk("b2b_co", (W+1)'(co), (W+1)'(1));

        if (SUB_EN) begin
            op(128'd5, 128'd7, 1'b0, 1'b1, 1'b0, nb);
            chk("sub_neg_s",  {1'b0, s}, {1'b0, ones - 128'd1});
            chk("sub_neg_co", (W+1)'(co), '0);
            op(128'd7, 128'd5, 1'b0, 1'b1, 1'b0, nb);
            chk("sub_pos_s",  {1'b0, s}, (W+1)'(2));
            chk("sub_pos_co", (W+1)'(co), (W+1)'(1));
        end

        repeat (400) begin
            @(posedge clk); #2;
            start = (($urandom % 3) == 0);
            a     = rnd_wide();
            b     = rnd_wide();
            ci    = 1'($urandom);
            sub   = 1'($urandom);
        end
        start = 1'b0;
        repeat (NWORDS + 4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
